// File: rtl/mem_unit.sv
// mem_unit: single-port word memory with a byte-stream program loader.
// The loader is compiled in only when MEM_LOAD_EN is defined.
module mem_unit #(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          e,
  input  logic          rw,
  input  logic [AW-1:0] MAR,
  input  logic [31:0]   wD,
  output logic [31:0]   rD,
  input  logic          ld_en,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic [AW:0]   ld_count
);

  logic [31:0]   mem [DEPTH];
  logic          loading;
  logic          ld_we;
  logic [AW-1:0] ld_addr;
  logic [31:0]   buffer;
  logic          cpu_rd;
  logic          cpu_wr;

  assign cpu_rd = e & ~rw & ~loading;
  assign cpu_wr = e & rw & ~loading;

`ifdef MEM_LOAD_EN
  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE
  } state_t;

  state_t     state;
  logic [1:0] idx;

  assign loading = (state != IDLE);
  assign ld_we   = (state == WRITE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      ld_addr  <= '0;
      ld_count <= '0;
      ld_ready <= 1'b0;
      buffer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          ld_ready <= 1'b0;
          if (ld_en) begin
            state    <= COLLECT;
            ld_ready <= 1'b1;
            idx      <= '0;
            ld_addr  <= '0;
            ld_count <= '0;
          end
        end
        COLLECT: begin
          if (!ld_en) begin
            state    <= IDLE;
            ld_ready <= 1'b0;
            idx      <= '0;
          end else if (ld_valid && ld_ready) begin
            // shift in big-endian: first byte ends up in [31:24]
            buffer <= {buffer[23:0], ld_byte};
            idx    <= idx + 2'd1;
            if (idx == 2'd3) begin
              state    <= WRITE;
              ld_ready <= 1'b0;
            end
          end
        end
        WRITE: begin
          ld_addr <= (ld_addr == AW'(DEPTH - 1)) ?
                     '0 : ld_addr + AW'(1);
          if (ld_count != (AW+1)'(DEPTH))
            ld_count <= ld_count + (AW+1)'(1);
          idx <= '0;
          if (ld_en) begin
            state    <= COLLECT;
            ld_ready <= 1'b1;
          end else begin
            state    <= IDLE;
            ld_ready <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end
`else
  logic unused;

  assign loading  = 1'b0;
  assign ld_we    = 1'b0;
  assign ld_addr  = '0;
  assign buffer   = '0;
  assign ld_ready = 1'b0;
  assign ld_count = '0;
  assign unused   = ^{ld_en, ld_valid, ld_byte};
`endif

  // storage is deliberately outside the reset domain
  always_ff @(posedge clk) begin
    if (ld_we)
      mem[ld_addr] <= buffer;
    else if (cpu_wr)
      mem[MAR] <= wD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rD <= '0;
    else if (cpu_rd)
      rD <= mem[MAR];
  end

endmodule

// File: doc/mem_unit.md
MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words (address width 10).
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 e  input  1  CPU port enable.
REQ-006 rw  input  1  CPU port direction: 0 = read, 1 = write.
REQ-007 MAR  input  10  CPU word address.
REQ-008 wD  input  32  CPU write data.
REQ-009 rD  output  32  CPU read data (registered).
REQ-010 ld_en  input  1  program-load mode request.
REQ-011 ld_valid  input  1  load byte valid.
REQ-012 ld_byte  input  8  load byte.
REQ-013 ld_ready  output  1  load byte accepted when ld_valid & ld_ready at a clock edge.
REQ-014 ld_count  output  11  words written in the current load session (saturates at 1024).

Function
REQ-015 The CPU port SHALL perform a read on each edge where e=1, rw=0 and the block is not loading: rD <= mem[MAR]; data is valid one cycle after the address is sampled, so an address driven after edge N is readable at edge N+2.
REQ-016 The CPU port SHALL perform a write on each edge where e=1, rw=1 and the block is not loading: mem[MAR] <= wD; rD holds its value; with rw held high for several cycles, the last sampled MAR/wD pair wins.
REQ-017 With e=0, rD SHALL hold its value and memory SHALL NOT change.
REQ-018 The loader FSM SHALL have states IDLE, COLLECT, WRITE.
- IDLE: ld_ready=0; on ld_en=1, go to COLLECT with byte index 0, ld_addr=0, ld_count=0.
- COLLECT: ld_ready=1; each accepted byte goes into the word buffer big-endian (first byte -> [31:24]); the 4th byte moves the FSM to WRITE.
- WRITE: ld_ready=0 for exactly one cycle; mem[ld_addr] <= buffer; ld_addr increments; ld_count increments (saturates); return to COLLECT.
REQ-019 ld_addr SHALL wrap 1023 -> 0; a 1025th word overwrites address 0, and ld_count stays at 1024.
REQ-020 ld_en=0 in COLLECT or WRITE SHALL return the FSM to IDLE next edge; a partial word SHALL be discarded; a word in WRITE that cycle SHALL still be written.
REQ-021 While the FSM is not IDLE (loading), CPU reads and writes SHALL be ignored and rD SHALL hold.
REQ-022 A CPU access on the same edge that ld_en first rises SHALL still complete; the loader takes priority from the next edge.
REQ-023 ld_count SHALL hold its final value in IDLE until the next session starts.

Reset
REQ-024 Asserting reset SHALL immediately set rD=0, ld_ready=0, ld_count=0, byte index=0, ld_addr=0, FSM=IDLE, buffer=0.
REQ-025 Memory contents SHALL NOT be altered by reset.
REQ-026 Reset mid-load SHALL abort the session; words already written remain in memory.

Configuration
REQ-027 Macro MEM_LOAD_EN: when defined, the loader (REQ-018..023) SHALL be compiled in.
REQ-028 Without MEM_LOAD_EN: ld_en, ld_valid and ld_byte SHALL be ignored; ld_ready and ld_count SHALL be constant 0; the CPU port is never blocked.

Verification
REQ-029 CPU write/read: write 0xDEADBEEF to MAR=5 (e=1, rw=1), then read MAR=5 -> rD=0xDEADBEEF on the edge after the read is sampled; before that edge, rD shows its old value.
REQ-030 Load: ld_en=1, bytes 01 02 03 04 05 06 07 08 -> mem[0]=0x01020304, mem[1]=0x05060708, ld_count=2, ld_ready low one cycle after each 4th byte.
REQ-031 Abort: 6 bytes, then ld_en=0 -> mem[0] written, mem[1] unchanged, ld_count=1, FSM IDLE.
REQ-032 Wrap: load 1025 words (word k = k) -> mem[0]=1024, mem[1]=1, ld_count=1024.
REQ-033 Blocking: ld_en=1 while CPU writes 0x55 to MAR=9 -> mem[9] unchanged, rD held; same access after ld_en=0 succeeds.
REQ-034 Reset: assert reset asynchronously mid-byte -> rD=0, ld_ready=0, ld_count=0 immediately; previously written mem[0] retained and readable afterwards.
